sync_fifo_v2: RTL and testbench

Parametrised single-clock FIFO, successor to the team's basic buffering FIFO. Adds:
- programmable almost-full/almost-empty thresholds
- a fill-level count output
- a synchronous flush
- a compile-time selectable first-word-fall-through (FWFT) read mode

Sits between byte/word producers (UART/SCI receivers, packet framers) and consumers that need back-pressure headroom.

---
 rtl/sync_fifo_v2.sv | 135 +++++++++++++
 tb/tb_sync_fifo_v2.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with level flags, fill count, flush and optional FWFT read.
// Ports: clk, rst_n, clear, valid/din (write), load (read/pop), dout, fifo_valid,
//   full, empty, almost_full, almost_empty, count; macro SYNC_FIFO_ERR_FLAGS_EN
//   adds sticky overflow/underflow outputs.
module sync_fifo_v2 #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 512,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     valid,
  input  logic [WIDTH-1:0]         din,
  input  logic                     load,
  output logic [WIDTH-1:0]         dout,
  output logic                     fifo_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                     overflow,
  output logic                     underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_L = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_L = (AW+1)'(AE_LEVEL);

`ifndef SYNTHESIS
  initial begin
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0)
      $error("sync_fifo_v2: DEPTH must be a power of two >= 4");
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH)
      $error("sync_fifo_v2: AF_LEVEL out of range");
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1)
      $error("sync_fifo_v2: AE_LEVEL out of range");
  end
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // full: same slot, opposite lap
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});

  assign wr_en = valid && !full && !clear;
  assign rd_en = load && !empty && !clear;

  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        wr_en && !rd_en: count <= count + 1'b1;
        rd_en && !wr_en: count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // head word is always presented; load pops it
      assign dout       = mem[rd_ptr[AW-1:0]];
      assign fifo_valid = !empty;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      logic             fv_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
          fv_q   <= 1'b0;
        end else if (clear) begin
          fv_q   <= 1'b0;
        end else if (rd_en) begin
          dout_q <= mem[rd_ptr[AW-1:0]];
          fv_q   <= 1'b1;
        end else begin
          fv_q   <= 1'b0;
        end
      end

      assign dout       = dout_q;
      assign fifo_valid = fv_q;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (valid && full)
        overflow  <= 1'b1;
      if (load && empty)
        underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Randomised + directed bench for sync_fifo_v2 (standard and FWFT instances).
// Queue model checked every cycle, plus literal expectations from the test plan.
module tb_sync_fifo_v2;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 1;

  logic         clk = 0;
  logic         rst_n = 1;
  logic         clear = 0;
  logic         valid = 0;
  logic [W-1:0] din = 0;
  logic         load = 0;

  logic [W-1:0] dout0, dout1;
  logic         fv0, fv1, full0, full1, empty0, empty1;
  logic         af0, af1, ae0, ae1;
  logic [3:0]   cnt0, cnt1;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic         ovf0, ovf1, udf0, udf1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit go = 0;

  always #5 clk = ~clk;

  sync_fifo_v2 #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid(valid), .din(din),
    .load(load), .dout(dout0), .fifo_valid(fv0), .full(full0),
    .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(cnt0)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(ovf0), .underflow(udf0)
`endif
  );

  sync_fifo_v2 #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid(valid), .din(din),
    .load(load), .dout(dout1), .fifo_valid(fv1), .full(full1),
    .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(cnt1)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(ovf1), .underflow(udf1)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference model: a queue of words plus the registered read port
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout = 0;
  bit           m_fv = 0;
  bit           m_ovf = 0;
  bit           m_udf = 0;

  always @(posedge clk or negedge rst_n) begin
    bit wr, rd;
    if (!rst_n) begin
      q.delete();
      m_dout = 0;
      m_fv = 0;
      m_ovf = 0;
      m_udf = 0;
    end else if (clear) begin
      q.delete();
      m_fv = 0;
      m_ovf = 0;
      m_udf = 0;
    end else begin
      wr = valid && (q.size() < D);
      rd = load && (q.size() > 0);
      if (valid && q.size() == D) m_ovf = 1;
      if (load && q.size() == 0) m_udf = 1;
      if (rd) begin
        m_dout = q.pop_front();
        m_fv = 1;
      end else begin
        m_fv = 0;
      end
      if (wr) q.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("count0", cnt0, q.size());
      chk("count1", cnt1, q.size());
      chk("empty0", empty0, q.size() == 0);
      chk("empty1", empty1, q.size() == 0);
      chk("full0", full0, q.size() == D);
      chk("full1", full1, q.size() == D);
      chk("af0", af0, q.size() >= AF);
      chk("af1", af1, q.size() >= AF);
      chk("ae0", ae0, q.size() <= AE);
      chk("ae1", ae1, q.size() <= AE);
      chk("fv_std", fv0, m_fv);
      chk("dout_std", dout0, m_dout);
      chk("fv_fwft", fv1, q.size() != 0);
      if (q.size() != 0) chk("dout_fwft", dout1, q[0]);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("ovf0", ovf0, m_ovf);
      chk("udf0", udf0, m_udf);
      chk("ovf1", ovf1, m_ovf);
      chk("udf1", udf1, m_udf);
`endif
    end
  end

  task automatic cyc(input bit v, input bit l, input logic [W-1:0] d, input bit c);
    valid = v;
    load  = l;
    din   = d;
    clear = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst_n = 0;
    #20;
    chk("rst_count", cnt0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_ae", ae0, 1);
    chk("rst_af", af0, 0);
    chk("rst_fv", fv0, 0);
    chk("rst_dout", dout0, 0);
    @(posedge clk);
    #1 rst_n = 1;
    go = 1;

    // fill
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, W'(i), 0);
      chk("fill_count", cnt0, i);
      if (i == 1) chk("fill_ae1", ae0, 1);
      if (i == 2) chk("fill_ae2", ae0, 0);
      if (i == 5) chk("fill_af5", af0, 0);
      if (i == 6) chk("fill_af6", af0, 1);
    end
    chk("fill_full", full0, 1);
    cyc(1, 0, 8'hFF, 0);
    chk("ovf_count", cnt0, 8);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("ovf_flag", ovf0, 1);
`endif

    // drain
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0, 0);
      chk("drain_dout", dout0, i);
      chk("drain_fv", fv0, 1);
    end
    chk("drain_empty", empty0, 1);
    cyc(0, 1, 0, 0);
    chk("udf_fv", fv0, 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("udf_flag", udf0, 1);
`endif

    // simultaneous access at count 4 across wrap
    for (int i = 0; i < 4; i++) cyc(1, 0, W'(8'h10 + i), 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, W'(8'h20 + i), 0);
      chk("sim_count", cnt0, 4);
      chk("sim_dout", dout0, (i < 4) ? (32'h10 + i) : (32'h20 + i - 4));
    end

    // boundaries
    for (int i = 0; i < 4; i++) cyc(1, 0, W'(8'h40 + i), 0);
    chk("bnd_full", full0, 1);
    cyc(1, 1, 8'h99, 0);
    chk("bnd_full_rw", cnt0, 7);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0);
    chk("bnd_drained", empty0, 1);
    cyc(1, 1, 8'h55, 0);
    chk("bnd_empty_rw", cnt0, 1);
    chk("bnd_empty_fv", fv0, 0);

    // FWFT
    cyc(0, 1, 0, 0);
    cyc(1, 0, 8'hA5, 0);
    chk("fwft_dout", dout1, 8'hA5);
    chk("fwft_fv", fv1, 1);
    cyc(0, 0, 0, 0);
    chk("fwft_hold", fv1, 1);
    cyc(0, 1, 0, 0);
    chk("fwft_pop_fv", fv1, 0);
    chk("fwft_pop_empty", empty1, 1);

    // flush
    for (int i = 0; i < 5; i++) cyc(1, 0, W'(8'h60 + i), 0);
    chk("flush_pre", cnt0, 5);
    cyc(1, 1, 8'h77, 1);
    chk("flush_count", cnt0, 0);
    chk("flush_empty", empty0, 1);
    chk("flush_fv", fv0, 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("flush_ovf", ovf0, 0);
    chk("flush_udf", udf0, 0);
`endif

    // random traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
          W'($urandom), $urandom_range(0, 49) == 0);
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
          W'($urandom), $urandom_range(0, 49) == 0);

    // reset mid-burst
    for (int i = 0; i < 3; i++) cyc(1, 1, W'(8'hB0 + i), 0);
    cyc(1, 0, 8'hC0, 0);
    rst_n = 0;
    #2;
    chk("arst_count", cnt0, 0);
    chk("arst_empty", empty0, 1);
    chk("arst_full", full0, 0);
    chk("arst_ae", ae0, 1);
    chk("arst_af", af0, 0);
    chk("arst_fv", fv0, 0);
    chk("arst_dout", dout0, 0);
    chk("arst_fv1", fv1, 0);
    @(negedge clk);
    rst_n = 1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
